// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: direction/mode constants and the shared next-count function
// used by every counter_bank channel.
package counter_bank_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Widest channel the function supports; callers zero-extend in and truncate out.
    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] next;
        logic                 term;
    } step_t;

    // +1 only happens below limit and -1 only above zero, so no carry ever leaves WIDTH.
    function automatic step_t next_count(
        input logic [MAX_WIDTH-1:0] value,
        input logic [MAX_WIDTH-1:0] limit,
        input logic                 dir,
        input logic                 sat
    );
        step_t res;
        res.next = value;
        res.term = 1'b0;
        if (dir == DIR_DOWN) begin
            if (value == '0) begin
                res.term = 1'b1;
                res.next = (sat == MODE_WRAP) ? limit : '0;
            end else begin
                res.next = value - 1'b1;
            end
        end else if (value >= limit) begin
            res.term = 1'b1;
            res.next = (sat == MODE_SAT) ? limit : '0;
        end else begin
            res.next = value + 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_channel.sv
// counter_channel: one up/down counter with clr > load > step > hold priority,
// a one-cycle terminal pulse and a sticky reached flag.
module counter_channel
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             m_clock,
    input  logic             p_reset,
    input  logic             tick,
    input  logic             cnt_en,
    input  logic             dir,
    input  logic             sat_mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] value,
    output logic             tc,
    output logic             reached,
    output logic             reached_next
);

    step_t            step_res;
    logic [WIDTH-1:0] value_d;
    logic             tc_d;

    always_comb begin
        step_res     = next_count(MAX_WIDTH'(value), MAX_WIDTH'(limit), dir, sat_mode);
        value_d      = value;
        tc_d         = 1'b0;
        reached_next = reached;
        if (clr) begin
            value_d      = '0;
            reached_next = 1'b0;
        end else if (load) begin
            value_d      = load_value;
            reached_next = 1'b0;
        end else if (cnt_en && tick) begin
            value_d = step_res.next[WIDTH-1:0];
            tc_d    = step_res.term;
            if (step_res.term) begin
                reached_next = 1'b1;
            end
        end
    end

    if (WIDTH < MAX_WIDTH) begin : g_trim
        logic unused_step_hi;
        assign unused_step_hi = ^step_res.next[MAX_WIDTH-1:WIDTH];
    end

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            value   <= '0;
            tc      <= 1'b0;
            reached <= 1'b0;
        end else begin
            value   <= value_d;
            tc      <= tc_d;
            reached <= reached_next;
        end
    end

endmodule

// File: rtl/counter_bank.sv
// counter_bank: CHANNELS independent up/down counters plus an aggregate done flag.
// Define COUNTER_BANK_PRESCALE_EN to gate all count steps with a shared PRESCALE divider.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 1
) (
    input  logic                      m_clock,
    input  logic                      p_reset,
    input  logic [CHANNELS-1:0]       cnt_en,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       sat_mode,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    input  logic [CHANNELS*WIDTH-1:0] limit,
    output logic [CHANNELS*WIDTH-1:0] value,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       reached,
    output logic                      done
);

    logic                tick;
    logic [CHANNELS-1:0] reached_next;

`ifdef COUNTER_BANK_PRESCALE_EN
    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q;

    // Free-running from reset; clr/load never touch it, so tick phase is bank-wide.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            ps_q <= '0;
        end else if (ps_q == PS_LAST) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_q + 1'b1;
        end
    end

    assign tick = (ps_q == PS_LAST);
`else
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign tick            = 1'b1;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        counter_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .m_clock     (m_clock),
            .p_reset     (p_reset),
            .tick        (tick),
            .cnt_en      (cnt_en[i]),
            .dir         (dir[i]),
            .sat_mode    (sat_mode[i]),
            .clr         (clr[i]),
            .load        (load[i]),
            .load_value  (load_value[i*WIDTH +: WIDTH]),
            .limit       (limit[i*WIDTH +: WIDTH]),
            .value       (value[i*WIDTH +: WIDTH]),
            .tc          (tc[i]),
            .reached     (reached[i]),
            .reached_next(reached_next[i])
        );
    end

    // Built from next-state so done rises on the same edge as the last reached bit.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            done <= 1'b0;
        end else begin
            done <= &reached_next;
        end
    end

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: scenario tasks push expected per-edge results into a scoreboard
// queue and pop/compare them one cycle later against the counter_bank outputs.
module tb_counter_bank;

    localparam int W = 8;
    localparam int N = 4;
`ifdef COUNTER_BANK_PRESCALE_EN
    localparam int PS = 3;
`else
    localparam int PS = 1;
`endif

    logic           m_clock;
    logic           p_reset;
    logic [N-1:0]   cnt_en, dir, sat_mode, clr, load;
    logic [N*W-1:0] load_value, limit;
    logic [N*W-1:0] value;
    logic [N-1:0]   tc, reached;
    logic           done;

    typedef struct {
        int         ch;
        logic [W-1:0] value;
        logic       tc;
        logic       reached;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    counter_bank #(
        .WIDTH(W), .CHANNELS(N), .PRESCALE(PS)
    ) dut (
        .m_clock(m_clock), .p_reset(p_reset), .cnt_en(cnt_en), .dir(dir),
        .sat_mode(sat_mode), .clr(clr), .load(load), .load_value(load_value),
        .limit(limit), .value(value), .tc(tc), .reached(reached), .done(done)
    );

    initial begin
        m_clock = 1'b0;
        forever #5 m_clock = ~m_clock;
    end

    task automatic apply_reset();
        p_reset    = 1'b1;
        cnt_en     = '0;
        dir        = '0;
        sat_mode   = '0;
        clr        = '0;
        load       = '0;
        load_value = '0;
        limit      = '0;
        repeat (2) @(posedge m_clock);
        #1 p_reset = 1'b0;
    endtask

    task automatic step_clk();
        @(posedge m_clock);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 4;
        if (value !== '0) begin
            failures++;
            $display("FAIL reset value: got %0h expected 0", value);
        end
        if (tc !== '0) begin
            failures++;
            $display("FAIL reset tc: got %b expected 0", tc);
        end
        if (reached !== '0) begin
            failures++;
            $display("FAIL reset reached: got %b expected 0", reached);
        end
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset done: got %b expected 0", done);
        end
    endtask

    // ch0 up/wrap limit 3: 1,2,3,0(tc),1,2,3
    task automatic test_up_wrap();
        exp_t e;
        logic [W-1:0] v = '0;
        logic r = 1'b0, t;
        apply_reset();
        limit[0 +: W] = 8'd3;
        dir[0] = 1'b1;
        cnt_en[0] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            t = (v >= 8'd3);
            v = t ? 8'd0 : v + 8'd1;
            r = r | t;
            sb.push_back('{ch: 0, value: v, tc: t, reached: r, done: 1'b0});
            step_clk();
            e = sb.pop_front();
            checks++;
            if (value[e.ch*W +: W] !== e.value || tc[e.ch] !== e.tc || reached[e.ch] !== e.reached || done !== e.done) begin
                failures++;
                $display("FAIL up_wrap k=%0d ch%0d: value=%0h tc=%b reached=%b done=%b, expected value=%0h tc=%b reached=%b done=%b",
                         k, e.ch, value[e.ch*W +: W], tc[e.ch], reached[e.ch], done, e.value, e.tc, e.reached, e.done);
            end
        end
    endtask

    // ch1 down/sat, load 2: 2,1,0,0(tc),0(tc),0(tc)
    task automatic test_down_sat();
        exp_t e;
        logic [W-1:0] v = '0;
        logic r = 1'b0, t;
        apply_reset();
        limit[W +: W] = 8'd9;
        load_value[W +: W] = 8'd2;
        sat_mode[1] = 1'b1;
        cnt_en[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            load[1] = (k == 0);
            if (k == 0) begin
                v = 8'd2; t = 1'b0; r = 1'b0;
            end else begin
                t = (v == 8'd0);
                v = t ? 8'd0 : v - 8'd1;
                r = r | t;
            end
            sb.push_back('{ch: 1, value: v, tc: t, reached: r, done: 1'b0});
            step_clk();
            e = sb.pop_front();
            checks++;
            if (value[e.ch*W +: W] !== e.value || tc[e.ch] !== e.tc || reached[e.ch] !== e.reached || done !== e.done) begin
                failures++;
                $display("FAIL down_sat k=%0d ch%0d: value=%0h tc=%b reached=%b done=%b, expected value=%0h tc=%b reached=%b done=%b",
                         k, e.ch, value[e.ch*W +: W], tc[e.ch], reached[e.ch], done, e.value, e.tc, e.reached, e.done);
            end
        end
    endtask

    // ch2 up/sat: load FE under limit FF -> FF held; load 10 above limit 5 -> 5 terminal
    task automatic test_up_sat_load();
        exp_t e;
        logic [W-1:0] v = '0, lim, lv;
        logic r = 1'b0, t;
        apply_reset();
        dir[2] = 1'b1;
        sat_mode[2] = 1'b1;
        cnt_en[2] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            lim = (k >= 4) ? 8'h05 : 8'hFF;
            lv  = (k == 0) ? 8'hFE : 8'h10;
            limit[2*W +: W] = lim;
            load_value[2*W +: W] = lv;
            load[2] = (k == 0 || k == 4);
            if (load[2]) begin
                v = lv; t = 1'b0; r = 1'b0;
            end else begin
                t = (v >= lim);
                v = t ? lim : v + 8'd1;
                r = r | t;
            end
            sb.push_back('{ch: 2, value: v, tc: t, reached: r, done: 1'b0});
            step_clk();
            e = sb.pop_front();
            checks++;
            if (value[e.ch*W +: W] !== e.value || tc[e.ch] !== e.tc || reached[e.ch] !== e.reached || done !== e.done) begin
                failures++;
                $display("FAIL up_sat_load k=%0d ch%0d: value=%0h tc=%b reached=%b done=%b, expected value=%0h tc=%b reached=%b done=%b",
                         k, e.ch, value[e.ch*W +: W], tc[e.ch], reached[e.ch], done, e.value, e.tc, e.reached, e.done);
            end
        end
    endtask

    // ch3 up/wrap limit 0: value stays 0 and tc is high on every step
    task automatic test_limit_zero();
        exp_t e;
        apply_reset();
        dir[3] = 1'b1;
        cnt_en[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{ch: 3, value: 8'd0, tc: 1'b1, reached: 1'b1, done: 1'b0});
            step_clk();
            e = sb.pop_front();
            checks++;
            if (value[e.ch*W +: W] !== e.value || tc[e.ch] !== e.tc || reached[e.ch] !== e.reached || done !== e.done) begin
                failures++;
                $display("FAIL limit_zero k=%0d ch%0d: value=%0h tc=%b reached=%b done=%b, expected value=%0h tc=%b reached=%b done=%b",
                         k, e.ch, value[e.ch*W +: W], tc[e.ch], reached[e.ch], done, e.value, e.tc, e.reached, e.done);
            end
        end
    endtask

    // ch0: clr+load+en on one edge clears; load 7 above limit 3 then wraps; async reset mid-count
    task automatic test_priority_reset();
        exp_t e;
        logic [W-1:0] v = '0;
        logic r = 1'b0, t;
        apply_reset();
        limit[0 +: W] = 8'd3;
        load_value[0 +: W] = 8'd7;
        dir[0] = 1'b1;
        cnt_en[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            clr[0]  = (k == 5);
            load[0] = (k == 5 || k == 6);
            t = 1'b0;
            if (clr[0]) begin
                v = 8'd0; r = 1'b0;
            end else if (load[0]) begin
                v = 8'd7; r = 1'b0;
            end else begin
                t = (v >= 8'd3);
                v = t ? 8'd0 : v + 8'd1;
                r = r | t;
            end
            sb.push_back('{ch: 0, value: v, tc: t, reached: r, done: 1'b0});
            step_clk();
            e = sb.pop_front();
            checks++;
            if (value[e.ch*W +: W] !== e.value || tc[e.ch] !== e.tc || reached[e.ch] !== e.reached || done !== e.done) begin
                failures++;
                $display("FAIL priority k=%0d ch%0d: value=%0h tc=%b reached=%b done=%b, expected value=%0h tc=%b reached=%b done=%b",
                         k, e.ch, value[e.ch*W +: W], tc[e.ch], reached[e.ch], done, e.value, e.tc, e.reached, e.done);
            end
        end
        clr = '0;
        load = '0;
        #2 p_reset = 1'b1;
        #1;
        checks++;
        if (value !== '0 || tc !== '0 || reached !== '0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: value=%0h tc=%b reached=%b done=%b, expected all zero", value, tc, reached, done);
        end
    endtask

    // ch0..3 up/wrap limits 1..4 reach terminal on edges 2..5; clr ch1 before edge 7
    task automatic test_done();
        exp_t e;
        logic [W-1:0] v[N];
        logic [W-1:0] lim[N];
        logic [N-1:0] r = '0;
        logic [N-1:0] t;
        int ch;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            v[i] = '0;
            lim[i] = W'(i + 1);
            limit[i*W +: W] = lim[i];
        end
        dir = '1;
        cnt_en = '1;
        for (int k = 0; k < 10; k++) begin
            clr[1] = (k == 6);
            for (int i = 0; i < N; i++) begin
                t[i] = 1'b0;
                if (clr[i]) begin
                    v[i] = '0; r[i] = 1'b0;
                end else begin
                    t[i] = (v[i] >= lim[i]);
                    v[i] = t[i] ? 8'd0 : v[i] + 8'd1;
                    r[i] = r[i] | t[i];
                end
            end
            ch = k % N;
            sb.push_back('{ch: ch, value: v[ch], tc: t[ch], reached: r[ch], done: &r});
            step_clk();
            e = sb.pop_front();
            checks++;
            if (value[e.ch*W +: W] !== e.value || tc[e.ch] !== e.tc || reached[e.ch] !== e.reached || done !== e.done) begin
                failures++;
                $display("FAIL done k=%0d ch%0d: value=%0h tc=%b reached=%b done=%b, expected value=%0h tc=%b reached=%b done=%b",
                         k, e.ch, value[e.ch*W +: W], tc[e.ch], reached[e.ch], done, e.value, e.tc, e.reached, e.done);
            end
        end
    endtask

`ifdef COUNTER_BANK_PRESCALE_EN
    // ch0 steps on edges 3,6,9; load on edge 4 bypasses the tick
    task automatic test_prescale();
        exp_t e;
        logic [W-1:0] v = '0;
        int ps = 0;
        logic tk;
        apply_reset();
        limit[0 +: W] = 8'hFF;
        load_value[0 +: W] = 8'h40;
        dir[0] = 1'b1;
        cnt_en[0] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            load[0] = (k == 3);
            tk = (ps == PS - 1);
            ps = tk ? 0 : ps + 1;
            if (load[0]) v = 8'h40;
            else if (tk) v = v + 8'd1;
            sb.push_back('{ch: 0, value: v, tc: 1'b0, reached: 1'b0, done: 1'b0});
            step_clk();
            e = sb.pop_front();
            checks++;
            if (value[e.ch*W +: W] !== e.value || tc[e.ch] !== e.tc || reached[e.ch] !== e.reached || done !== e.done) begin
                failures++;
                $display("FAIL prescale k=%0d ch%0d: value=%0h tc=%b reached=%b done=%b, expected value=%0h tc=%b reached=%b done=%b",
                         k, e.ch, value[e.ch*W +: W], tc[e.ch], reached[e.ch], done, e.value, e.tc, e.reached, e.done);
            end
        end
    endtask
`endif

    initial begin
        p_reset = 1'b1;
        test_reset();
`ifdef COUNTER_BANK_PRESCALE_EN
        test_prescale();
`else
        test_up_wrap();
        test_down_sat();
        test_up_sat_load();
        test_limit_zero();
        test_priority_reset();
        test_done();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_bank.md
# counter_bank

Parametrised multi-channel up/down counter bank, successor to the single free-running 32-bit counter/incrementer pair. Each channel has load, clear, enable, direction, a programmable limit, and either wrap or saturate terminal behaviour. Each channel produces a one-cycle terminal-count pulse and a sticky reached flag, and the bank produces an aggregate done flag. It sits beside the control FSMs as a shared timing/event-count resource and replaces ad-hoc `cnt >= constant` compares.

## Interface
Parameters:
- WIDTH, 32, bits per channel counter (≥2)
- CHANNELS, 4, number of independent channels (≥1)
- PRESCALE, 1, step divider; used only with COUNTER_BANK_PRESCALE_EN (≥1)

Ports (flattened vectors: channel i occupies bits [i*WIDTH +: WIDTH] or bit [i]):
- m_clock  in  1  clock, rising edge
- p_reset  in  1  asynchronous, active-high reset
- cnt_en  in  CHANNELS  per-channel count enable
- dir  in  CHANNELS  1 = up, 0 = down
- sat_mode  in  CHANNELS  1 = saturate, 0 = wrap
- clr  in  CHANNELS  synchronous clear to 0
- load  in  CHANNELS  synchronous load of load_value
- load_value  in  CHANNELS*WIDTH  load data
- limit  in  CHANNELS*WIDTH  terminal value for up-count, reload value for down-wrap
- value  out  CHANNELS*WIDTH  registered count
- tc  out  CHANNELS  one-cycle terminal-count pulse, registered
- reached  out  CHANNELS  sticky flag, registered
- done  out  1  AND of all reached bits, registered

## Operation
- Per-channel priority, evaluated each rising edge: clr > load > step > hold.
- clr: value←0, reached←0, tc←0.
- load: value←load_value, reached←0, tc←0.
- A step occurs when cnt_en=1 and the step tick is 1. The tick is always 1 without the macro.
- Up step, value < limit: value←value+1.
- Up step, value ≥ limit (terminal): wrap → value←0; saturate → value←limit. In both modes tc←1 and reached←1.
- Down step, value ≠ 0: value←value−1.
- Down step, value = 0 (terminal): wrap → value←limit; saturate → value holds at 0. In both modes tc←1 and reached←1.
- Saturated channel: every further terminal step re-pulses tc. Tc therefore stays high while enabled at the terminal value. This is intentional; it lets users count overflow cycles.
- limit = 0 with up-count: every step is terminal. Wrap holds 0 and tc is continuously 1.
- Arithmetic is modulo 2^WIDTH, unsigned. A load above limit is legal; the next up step is terminal.
- done←&reached_next, so it updates in the same cycle as the last reached bit.
- Channels are fully independent. The same-cycle clr/load of one channel does not affect others except through done.

## Timing
- All outputs are registered. The effect of inputs sampled at edge k is visible after edge k.
- Reset (async assert, sync-safe deassert by the user): value=0, tc=0, reached=0, done=0, prescaler=0.
- tc is high exactly one cycle per terminal step and is low on any cycle without a terminal step.
- Reset mid-count clears immediately and asynchronously, regardless of the other inputs.

## Configuration
- COUNTER_BANK_PRESCALE_EN defined: a shared prescaler counts 0..PRESCALE−1 from reset. The step tick is 1 on the cycle the prescaler equals PRESCALE−1 (first tick at the PRESCALE-th edge after reset release). PRESCALE=1 gives a tick every cycle. clr and load ignore the tick.
- Macro undefined: no prescaler logic, tick is constant 1, and PRESCALE is ignored.

## Structure
- Package counter_bank_pkg holds the following:
  - DIR_UP=1 / DIR_DOWN=0 constants.
  - MODE_WRAP=0 / MODE_SAT=1 constants.
  - A next-value function over WIDTH (value, limit, dir, sat) returning next value and terminal flag.
- Sub-module counter_channel holds one channel's value, tc and reached registers. It is instantiated CHANNELS times via generate.
- The top holds the prescaler and done.

## Test plan
- WIDTH=8, ch0 up, wrap, limit=3, enabled from reset: value 1,2,3,0,1… and tc high on the cycle value shows 0. reached=1 from that edge.
- ch1 down, saturate, load_value=2: value 1, then 0, then 0 held, with tc high on every cycle after value first reaches 0.
- ch2 up, saturate, limit=0xFF, load 0xFE: value FF, then FF held. Load 0x10 with limit=5 → next step is terminal, value→5.
- Same edge clr=1, load=1, cnt_en=1 on ch0: value=0 and reached cleared. Assert p_reset mid-count → all outputs 0 immediately.
- All four channels reach terminal on different cycles: done rises on the edge of the last reached, stays high, and falls on the edge after any clr.
- With COUNTER_BANK_PRESCALE_EN, PRESCALE=3, ch0 up enabled: value increments on edges 3,6,9. A load on edge 4 takes effect on edge 4.
